// File: rtl/axis_video_timing_out_if.sv
// axis_video_timing_out_if: AXI4-Stream video pixel channel carrying SOF in tuser and EOL in tlast
interface axis_video_timing_out_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] tdata;
  logic tvalid;
  logic tuser;
  logic tlast;
  logic tready;
  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/axis_video_timing_out.sv
// axis_video_timing_out: raster timing generator displaying an AXI4-Stream pixel stream locked to SOF/EOL
module axis_video_timing_out #(
  parameter int DATA_W = 24,
  parameter int H_ACTIVE = 1280,
  parameter int H_FP = 110,
  parameter int H_SYNC = 40,
  parameter int H_BP = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP = 5,
  parameter int V_SYNC = 5,
  parameter int V_BP = 20,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1,
  parameter logic [DATA_W-1:0] BG_COLOR = '0
) (
  input  logic pixel_clk,
  input  logic sys_rst_n,
  axis_video_timing_out_if.slave s_axis,
  output logic video_hs,
  output logic video_vs,
  output logic video_de,
  output logic [DATA_W-1:0] video_rgb,
  output logic locked,
  output logic underflow,
  output logic align_err
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  typedef enum logic {SEEK, LOCK} state_t;
  state_t state, state_nxt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic h_end, v_end, de_i, hs_i, vs_i, first_px, last_px, acc, uf_nxt, ae_nxt;
  logic [DATA_W-1:0] rgb_nxt;
  assign h_end = h_cnt == HW'(H_TOTAL - 1);
  assign v_end = v_cnt == VW'(V_TOTAL - 1);
  assign de_i = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign hs_i = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
  assign vs_i = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));
  assign first_px = (h_cnt == '0) && (v_cnt == '0);
  assign last_px = (h_cnt == HW'(H_ACTIVE - 1)) && de_i;
  // SEEK flushes non-SOF beats and holds an SOF until the raster origin; LOCK never eats a misplaced SOF
  assign s_axis.tready = sys_rst_n && (state == SEEK ? s_axis.tvalid && (!s_axis.tuser || first_px)
                                                     : de_i && !(s_axis.tuser && !first_px));
  assign acc = s_axis.tvalid && s_axis.tready;
  always_comb begin
    state_nxt = state;
    rgb_nxt = de_i ? BG_COLOR : '0;
    uf_nxt = 1'b0;
    ae_nxt = 1'b0;
    if (state == SEEK) begin
      if (acc && s_axis.tuser) begin
        state_nxt = LOCK;
        rgb_nxt = s_axis.tdata;
      end
    end else if (de_i) begin
      uf_nxt = !s_axis.tvalid;
      ae_nxt = s_axis.tvalid && ((s_axis.tuser && !first_px) || (acc && (s_axis.tlast != last_px)));
      rgb_nxt = acc ? s_axis.tdata : BG_COLOR;
      state_nxt = (uf_nxt || ae_nxt) ? SEEK : LOCK;
    end
  end
  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      state <= SEEK;
      video_hs <= !HS_POL;
      video_vs <= !VS_POL;
      video_de <= 1'b0;
      video_rgb <= '0;
      locked <= 1'b0;
      underflow <= 1'b0;
      align_err <= 1'b0;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + 1'b1;
      if (h_end) v_cnt <= v_end ? '0 : v_cnt + 1'b1;
      state <= state_nxt;
      video_hs <= hs_i ~^ HS_POL;
      video_vs <= vs_i ~^ VS_POL;
      video_de <= de_i;
      video_rgb <= rgb_nxt;
      locked <= state_nxt == LOCK;
      underflow <= uf_nxt;
      align_err <= ae_nxt;
    end
  end
endmodule

// File: doc/axis_video_timing_out.md
# axis_video_timing_out

Parametrised video output stage that generates raster timing (hsync, vsync, data-enable) and pulls pixels from an AXI4-Stream slave. Frame alignment uses TUSER (start of frame) and line alignment uses TLAST (end of line). It sits between the pixel FIFO/AXIS source and the DVI/TMDS transmitter, in the pixel clock domain. It generalises the fixed-resolution driver with:
- configurable timing and sync polarity;
- configurable pixel width;
- SOF locking and resynchronisation;
- underflow and line-length error reporting.

## Interface
Parameters:
- DATA_W, 24, pixel width in bits
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- BG_COLOR, 0, pixel value driven during an active period with no valid data (DATA_W bits)

Ports:
- pixel_clk  in  1  pixel clock; the only clock
- sys_rst_n  in  1  synchronous, active-low reset
- s_axis_tdata  in  DATA_W  pixel
- s_axis_tvalid  in  1  beat valid
- s_axis_tuser  in  1  first pixel of frame (SOF)
- s_axis_tlast  in  1  last pixel of line (EOL)
- s_axis_tready  out  1  beat accepted when tvalid & tready
- video_hs  out  1  hsync, polarity HS_POL
- video_vs  out  1  vsync, polarity VS_POL
- video_de  out  1  data enable
- video_rgb  out  DATA_W  pixel out
- locked  out  1  high while stream is aligned to the raster
- underflow  out  1  one-cycle pulse: active pixel with no valid beat while locked
- align_err  out  1  one-cycle pulse: TLAST/TUSER position mismatch while locked

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL similarly.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments on each h_cnt wrap, runs 0..V_TOTAL-1, and wraps to 0.
  - Both counters are $clog2(total) bits wide.
- Raster order per axis: active, then FP, then sync, then BP.
  - de_i = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE).
  - hs_i active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs_i active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for whole lines.
- first_px = (h_cnt==0) & (v_cnt==0). last_px = (h_cnt==H_ACTIVE-1) & de_i.
- State machine with two states, SEEK and LOCK; reset state is SEEK.
- SEEK:
  - s_axis_tready = s_axis_tvalid & ~s_axis_tuser, so non-SOF beats are flushed.
  - A SOF beat is held at the head of the stream with tready low.
  - At first_px with tvalid & tuser: accept the beat, go to LOCK, and output tdata.
  - Otherwise active pixels output BG_COLOR.
- LOCK:
  - s_axis_tready = de_i & ~(s_axis_tuser & ~first_px). A misplaced SOF is never consumed.
  - Underflow: de_i & ~tvalid → underflow pulse, output BG_COLOR, go to SEEK.
  - Misplaced SOF: de_i & tvalid & tuser & ~first_px → align_err pulse, output BG_COLOR, go to SEEK. The SOF beat stays held for the next frame.
  - Accepted beat with tlast != last_px (early or missing EOL) → beat consumed and displayed, align_err pulse, go to SEEK.
  - Otherwise the accepted tdata is displayed.
- Blanking (de_i=0): video_rgb is 0, and tready is 0 in LOCK.
- locked = (state==LOCK), registered with the other outputs.

## Timing
- All outputs are registered. video_* and locked reflect the counter position and state of the previous cycle, so latency from counter to pins is 1 cycle.
- underflow and align_err pulse in the cycle after the offending counter position, aligned with the corresponding video_rgb.
- The AXIS handshake is evaluated combinationally on the current counter position. Exactly one beat is consumed per active pixel while in LOCK.
- Reset (sys_rst_n=0 at a pixel_clk edge), including mid-frame:
  - h_cnt=v_cnt=0, state=SEEK.
  - video_hs=~HS_POL, video_vs=~VS_POL, video_de=0, video_rgb=0.
  - locked=0, underflow=0, align_err=0.
  - s_axis_tready is forced to 0 while reset is asserted.
- After reset release, the first active pixel appears on the pins 1 cycle after (h,v)=(0,0), i.e. on the first clock after release.
- Underflow and align_err cannot coincide in one cycle; underflow requires ~tvalid and align_err requires tvalid.

## Test plan
Reduced parameters for all tests: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, so H_TOTAL=14 and V_TOTAL=7.
- Reset and raster, no stream:
  - hs active for 2 of every 14 cycles, starting 11 cycles after reset release (h=10 plus 1 latency).
  - vs active for 14 cycles per 98.
  - de high 8/14 on lines 0-3; rgb=BG_COLOR while de, 0 otherwise.
- Always-valid source, SOF on beat 0 and TLAST every 8th beat:
  - locked rises in cycle 1.
  - rgb reproduces the beats in order; exactly 32 beats consumed per frame.
  - No error pulses over 3 frames.
- Source idle for 3 cycles mid-line 2 while locked:
  - underflow pulses once; locked drops.
  - Remainder of frame shows BG_COLOR.
  - Relock at the next (0,0) once an SOF beat is present.
- TLAST on the 6th beat of a line:
  - align_err pulses aligned with that pixel; state goes to SEEK.
  - Non-SOF beats are flushed and the next frame relocks.
- Stream starting mid-frame with a stray non-SOF prefix of 5 beats:
  - Beats are flushed; the SOF is held with tready=0.
  - SOF accepted exactly at (0,0).
- Reset asserted at h=5, v=2 while locked:
  - The next cycle shows all outputs at their reset values and tready=0.
  - Raster restarts from (0,0).
